// File: rtl/norm_seq.sv
// Frame-based complex magnitude sequencer: gathers 4 samples, squares |re|+|im|
// of each through one shared saturating squarer, then holds all results for a handshake.
module norm_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inReal,
  input  logic [WIDTH-1:0] inImag,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outaDist,
  output logic [WIDTH-1:0] outbDist,
  output logic [WIDTH-1:0] outcDist,
  output logic [WIDTH-1:0] outdDist,
  output logic [1:0]       outMinIdx,
  output logic             busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       minIdx_q, minIdx_d;
  logic [WIDTH-1:0] minVal_q, minVal_d;
  logic [WIDTH-1:0] re_q   [4];
  logic [WIDTH-1:0] re_d   [4];
  logic [WIDTH-1:0] im_q   [4];
  logic [WIDTH-1:0] im_d   [4];
  logic [WIDTH-1:0] dist_q [4];
  logic [WIDTH-1:0] dist_d [4];

  logic [WIDTH-1:0]   selRe, selIm;
  logic [WIDTH:0]     reExt, imExt, absRe, absIm, absSum;
  logic [2*WIDTH+1:0] sqFull;
  logic [WIDTH-1:0]   sqSat;

  // Single shared squarer; one extra bit keeps |-2^(WIDTH-1)| exact.
  always_comb begin
    selRe  = re_q[idx_q];
    selIm  = im_q[idx_q];
    reExt  = {selRe[WIDTH-1], selRe};
    imExt  = {selIm[WIDTH-1], selIm};
    absRe  = reExt[WIDTH] ? (~reExt + (WIDTH+1)'(1)) : reExt;
    absIm  = imExt[WIDTH] ? (~imExt + (WIDTH+1)'(1)) : imExt;
    absSum = absRe + absIm;
    sqFull = (2*WIDTH+2)'(absSum) * (2*WIDTH+2)'(absSum);
    sqSat  = (|sqFull[2*WIDTH+1:WIDTH]) ? {WIDTH{1'b1}} : sqFull[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    minIdx_d = minIdx_q;
    minVal_d = minVal_q;
    re_d     = re_q;
    im_d     = im_q;
    dist_d   = dist_q;
    case (state_q)
      LOAD: begin
        if (inValid) begin
          re_d[cnt_q] = inReal;
          im_d[cnt_q] = inImag;
          cnt_d       = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = CALC;
        end
      end
      CALC: begin
        dist_d[idx_q] = sqSat;
        // Strict compare so ties keep the lowest index.
        if (idx_q == 2'd0 || sqSat < minVal_q) begin
          minVal_d = sqSat;
          minIdx_d = idx_q;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = HOLD;
      end
      HOLD: begin
        if (outReady) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      cnt_q    <= 2'd0;
      idx_q    <= 2'd0;
      minIdx_q <= 2'd0;
      minVal_q <= '0;
      for (int i = 0; i < 4; i++) begin
        re_q[i]   <= '0;
        im_q[i]   <= '0;
        dist_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      minIdx_q <= minIdx_d;
      minVal_q <= minVal_d;
      re_q     <= re_d;
      im_q     <= im_d;
      dist_q   <= dist_d;
    end
  end

  assign inReady   = (state_q == LOAD) && !rst;
  assign outValid  = (state_q == HOLD);
  assign busy      = (state_q == CALC) || (state_q == HOLD);
  assign outaDist  = dist_q[0];
  assign outbDist  = dist_q[1];
  assign outcDist  = dist_q[2];
  assign outdDist  = dist_q[3];
  assign outMinIdx = minIdx_q;

endmodule

// File: tb/tb_norm_seq.sv
// Scoreboard bench for norm_seq: directed frames push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_norm_seq;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [WIDTH-1:0] inReal = '0;
  logic [WIDTH-1:0] inImag = '0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [WIDTH-1:0] outaDist, outbDist, outcDist, outdDist;
  logic [1:0]       outMinIdx;
  logic             busy;

  always #5 clk = ~clk;

  norm_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .inReal(inReal), .inImag(inImag),
    .outValid(outValid), .outReady(outReady),
    .outaDist(outaDist), .outbDist(outbDist), .outcDist(outcDist), .outdDist(outdDist),
    .outMinIdx(outMinIdx), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [1:0]  mi;
  } frame_t;

  frame_t      expQ[$];
  frame_t      monE;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          prevHs = -1;
  int          lastHs = -1;
  int          acceptCount = 0;
  logic [15:0] fr[4];
  logic [15:0] fi[4];

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every output handshake must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst && inValid && inReady) acceptCount++;
    if (!rst && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: outValid=1 with no frame expected");
      end else begin
        monE = expQ.pop_front();
        checkOutput("distA", outaDist, monE.a);
        checkOutput("distB", outbDist, monE.b);
        checkOutput("distC", outcDist, monE.c);
        checkOutput("distD", outdDist, monE.d);
        checkOutput("minIdx", outMinIdx, monE.mi);
      end
      prevHs = lastHs;
      lastHs = cycle;
    end
  end

  task automatic applyStimulus(input logic [15:0] re, input logic [15:0] im, input bit gap);
    bit accepted;
    int waitCyc;
    accepted = 1'b0;
    waitCyc  = 0;
    inValid  = 1'b1;
    inReal   = re;
    inImag   = im;
    while (!accepted && waitCyc < 30) begin
      @(negedge clk);
      accepted = inReady;
      @(posedge clk);
      #1;
      waitCyc++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got inReady=0 for 30 cycles expected accept");
    end
    if (gap) begin
      inValid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyFrame(input bit gap);
    for (int i = 0; i < 4; i++) applyStimulus(fr[i], fi[i], gap);
  endtask

  // Called right after the edge that accepted sample 3.
  task automatic checkLatency();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("latencyLow", outValid, 0);
      checkOutput("busyCalc", busy, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("latencyHigh", outValid, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drainEmpty", expQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startAccepts;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", inReady, 0);
    checkOutput("rstOutValid", outValid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDistA", outaDist, 0);
    checkOutput("rstMinIdx", outMinIdx, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstInReady", inReady, 1);
    @(posedge clk);
    #1;

    // Basic frame
    outReady = 1'b1;
    expQ.push_back('{16'd49, 16'd1, 16'd0, 16'd40000, 2'd2});
    fr = '{16'd3, 16'hFFFF, 16'd0, 16'd100};
    fi = '{16'hFFFC, 16'd0, 16'd0, 16'hFF9C};
    applyFrame(1'b0);
    inValid = 1'b0;
    checkLatency();
    waitDrain();

    // Saturation
    expQ.push_back('{16'd65025, 16'd65535, 16'd65535, 16'd1, 2'd3});
    fr = '{16'd255, 16'd256, 16'h8000, 16'd0};
    fi = '{16'd0, 16'd0, 16'h8000, 16'hFFFF};
    applyFrame(1'b0);
    inValid = 1'b0;
    checkLatency();
    waitDrain();

    // Ties plus backpressure; inValid held high with junk through CALC/HOLD
    outReady = 1'b0;
    expQ.push_back('{16'd16, 16'd16, 16'd16, 16'd16, 2'd0});
    fr = '{16'd2, 16'd2, 16'd2, 16'd2};
    fi = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    applyFrame(1'b0);
    inReal = 16'd100;
    inImag = 16'd100;
    checkLatency();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("holdValid", outValid, 1);
      checkOutput("holdInReady", inReady, 0);
      checkOutput("holdDistA", outaDist, 16);
      checkOutput("holdDistD", outdDist, 16);
      checkOutput("holdMinIdx", outMinIdx, 0);
      @(posedge clk);
      #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("releaseValid", outValid, 0);
    checkOutput("releaseInReady", inReady, 1);
    checkOutput("releaseQueue", expQ.size(), 0);
    @(posedge clk);
    #1;

    // Gapped input, tie resolved to lowest index
    outReady = 1'b1;
    startAccepts = acceptCount;
    expQ.push_back('{16'd64, 16'd4, 16'd9, 16'd4, 2'd1});
    fr = '{16'd4, 16'hFFFF, 16'd0, 16'd2};
    fi = '{16'hFFFC, 16'd1, 16'd3, 16'd0};
    applyFrame(1'b1);
    waitDrain();
    checkOutput("gapAccepts", acceptCount - startAccepts, 4);

    // Reset after two CALC slots; partial frame must vanish
    fr = '{16'd7, 16'd0, 16'd1, 16'd1};
    fi = '{16'd0, 16'd7, 16'd1, 16'hFFFF};
    applyFrame(1'b0);
    inValid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid", outValid, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstInReady", inReady, 1);
    checkOutput("midRstDistA", outaDist, 0);
    checkOutput("midRstDistB", outbDist, 0);
    checkOutput("midRstDistC", outcDist, 0);
    checkOutput("midRstDistD", outdDist, 0);
    checkOutput("midRstMinIdx", outMinIdx, 0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    expQ.push_back('{16'd900, 16'd100, 16'd1, 16'd9, 2'd2});
    fr = '{16'd10, 16'hFFFB, 16'd0, 16'hFFFE};
    fi = '{16'hFFEC, 16'hFFFB, 16'd1, 16'd1};
    applyFrame(1'b0);
    inValid = 1'b0;
    checkLatency();
    waitDrain();

    // Back-to-back frames with outReady tied high
    expQ.push_back('{16'd1, 16'd4, 16'd9, 16'd16, 2'd0});
    expQ.push_back('{16'd36, 16'd25, 16'd9, 16'd1600, 2'd2});
    fr = '{16'd1, 16'd0, 16'd3, 16'd0};
    fi = '{16'd0, 16'd2, 16'd0, 16'hFFFC};
    applyFrame(1'b0);
    fr = '{16'hFFFA, 16'd5, 16'd0, 16'd20};
    fi = '{16'd0, 16'd0, 16'hFFFD, 16'hFFEC};
    applyFrame(1'b0);
    inValid = 1'b0;
    waitDrain();
    checkOutput("framePeriod", lastHs - prevHs, 9);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
